move_logger: RTL and testbench

MOVE_LOGGER -- requirements
Module: move_logger

---
 rtl/move_logger.sv | 205 ++++++++++++++++++++
 tb/tb_move_logger.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_logger.sv
// Chess-board move logger: queues square writes as 10-bit records and streams
// each one over an 8N1 UART as an address byte followed by a piece byte.
module move_logger #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [5:0]            wr_addr,
    input  logic [3:0]            wr_piece,
    input  logic                  clear,
    output logic                  uart_tx,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [9:0]              mem [DEPTH];
    logic [9:0]              record_reg;
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
    logic [DEPTH_LOG2:0]     count_reg;
    logic                    overflow_reg;
    logic                    full;
    logic                    push;
    logic                    drop;
    logic                    pop;

    // Fullness is taken from the registered count, so a pop in the same cycle
    // never makes room for a write that arrives while full.
    assign full = (count_reg == FULL_COUNT);
    assign push = wr_en && !clear && !full;
    assign drop = wr_en && !clear && full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_addr, wr_piece};
        end
        if (pop) begin
            record_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign fifo_count = count_reg;
    assign fifo_full  = full;
    assign overflow   = overflow_reg;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    tx_state_t          state_reg,    state_next;
    logic [CNT_W-1:0]   bit_cnt_reg,  bit_cnt_next;
    logic [2:0]         bit_idx_reg,  bit_idx_next;
    logic               byte_sel_reg, byte_sel_next;
    logic               uart_tx_reg,  uart_tx_next;
    logic               bit_end;
    logic [7:0]         byte0;
    logic [7:0]         byte1;
    logic [7:0]         tx_byte;

    // Bit 7 tags the byte type so a receiver can resynchronise mid-stream.
    assign byte0 = {2'b00,   record_reg[9:4]};
    assign byte1 = {4'b1000, record_reg[3:0]};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_mux
            assign tx_byte[gi] = byte_sel_reg ? byte1[gi] : byte0[gi];
        end
    endgenerate

    assign bit_end = (bit_cnt_reg == LAST_CNT);

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_sel_next = byte_sel_reg;
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                bit_idx_next = '0;
                if ((count_reg != '0) && !clear) begin
                    pop           = 1'b1;
                    byte_sel_next = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (!byte_sel_reg) begin
                        byte_sel_next = 1'b1;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so the pin itself is a flop.
    always_comb begin
        uart_tx_next = 1'b1;
        case (state_next)
            START:   uart_tx_next = 1'b0;
            DATA:    uart_tx_next = tx_byte[bit_idx_next];
            default: uart_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_sel_reg <= 1'b0;
            uart_tx_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_sel_reg <= byte_sel_next;
            uart_tx_reg  <= uart_tx_next;
        end
    end

    assign uart_tx = uart_tx_reg;
    assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_move_logger.sv
// Bench for move_logger: cycle model feeds an expected-byte scoreboard that a
// UART receiver drains; FIFO status outputs are compared every cycle.
module tb_move_logger;

    localparam int CPB        = 4;
    localparam int DL         = 2;
    localparam int DEPTH      = 4;
    localparam int REC_CYCLES = 20 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [5:0]    wr_addr;
    logic [3:0]    wr_piece;
    logic          clear;
    logic          uart_tx;
    logic [DL:0]   fifo_count;
    logic          fifo_full;
    logic          overflow;
    logic          tx_busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_q[$];
    logic [9:0]    m_fifo[$];
    int            m_timer   = 0;
    logic          m_ovf     = 1'b0;
    logic          mon_abort = 1'b0;

    move_logger #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_piece   (wr_piece),
        .clear      (clear),
        .uart_tx    (uart_tx),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .tx_busy    (tx_busy)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the edge, outputs are checked on the falling edge.
    task automatic step(input logic w, input logic [5:0] a, input logic [3:0] p,
                        input logic c, input logic r);
        logic       do_pop;
        logic       do_push;
        logic [9:0] rec;
        wr_en    = w;
        wr_addr  = a;
        wr_piece = p;
        clear    = c;
        rst      = r;
        @(posedge clk);
        if (r) begin
            m_fifo.delete();
            exp_q.delete();
            m_timer   = 0;
            m_ovf     = 1'b0;
            mon_abort = 1'b1;
        end else begin
            do_pop  = (m_timer == 0) && (m_fifo.size() > 0) && !c;
            do_push = w && !c && (m_fifo.size() < DEPTH);
            if (m_timer > 0) m_timer--;
            if (c) begin
                m_fifo.delete();
                m_ovf = 1'b0;
            end else begin
                if (w && (m_fifo.size() == DEPTH)) m_ovf = 1'b1;
                if (do_pop) begin
                    rec = m_fifo.pop_front();
                    exp_q.push_back({2'b00, rec[9:4]});
                    exp_q.push_back({4'b1000, rec[3:0]});
                    m_timer = REC_CYCLES;
                end
                if (do_push) m_fifo.push_back({a, p});
            end
        end
        @(negedge clk);
        check_eq("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
        check_eq("fifo_full", 32'(fifo_full), 32'(m_fifo.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("tx_busy", 32'(tx_busy), 32'(m_timer > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // UART receiver: samples each bit at its middle, compares against the scoreboard.
    initial begin
        logic [7:0] rx;
        logic       start_b;
        logic       stop_b;
        logic [7:0] e;
        rx = '0;
        start_b = 1'b0;
        stop_b = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                mon_abort = 1'b0;
                for (int c = 1; c <= 38; c++) begin
                    @(negedge clk);
                    if (c == 2) start_b = uart_tx;
                    if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) rx[(c - 6) / 4] = uart_tx;
                    if (c == 38) stop_b = uart_tx;
                end
                if (mon_abort) begin
                    $display("rx frame abandoned after reset");
                end else begin
                    check_eq("start_bit", 32'(start_b), 32'd0);
                    check_eq("stop_bit", 32'(stop_b), 32'd1);
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_byte", 32'(exp_q.size()), 32'd1);
                        $display("rx byte %02h with nothing expected", rx);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rx_byte", 32'(rx), 32'(e));
                        $display("rx byte %02h expected %02h", rx, e);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] v;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_piece = '0;
        clear    = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
        check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
        idle(2);

        // Single record, latency and frame length
        $display("write addr=64(oct) piece=e");
        step(1'b1, 6'o64, 4'hE, 1'b0, 1'b0);
        check_eq("lat_n1_line_idle", 32'(uart_tx), 32'd1);
        idle(1);
        check_eq("lat_n2_start_bit", 32'(uart_tx), 32'd0);
        idle(80);
        check_eq("single_done_busy", 32'(tx_busy), 32'd0);
        idle(5);
        check_eq("single_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: five writes while the first record is on the line
        $display("overflow burst");
        step(1'b1, 6'd1, 4'd1, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 6'(10 + i), 4'(i + 2), 1'b0, 1'b0);
        check_eq("burst_overflow", 32'(overflow), 32'd1);
        check_eq("burst_count", 32'(fifo_count), 32'd4);
        idle(5 * (REC_CYCLES + 1) + 10);
        check_eq("burst_drained", 32'(exp_q.size()), 32'd0);

        // Clear during byte 0 of an in-flight record with others queued
        $display("clear mid-record");
        step(1'b1, 6'd33, 4'h9, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 6'(40 + i), 4'(i + 8), 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 4'd0, 1'b1, 1'b0);
        check_eq("clear_count", 32'(fifo_count), 32'd0);
        check_eq("clear_overflow", 32'(overflow), 32'd0);
        idle(100);
        check_eq("clear_drained", 32'(exp_q.size()), 32'd0);

        // Write and clear on the same cycle
        $display("write with clear");
        step(1'b1, 6'd7, 4'h3, 1'b1, 1'b0);
        check_eq("wclr_count", 32'(fifo_count), 32'd0);
        check_eq("wclr_overflow", 32'(overflow), 32'd0);
        idle(10);

        // Reset during DATA of byte 1
        $display("reset mid-frame");
        step(1'b1, 6'd21, 4'h5, 1'b0, 1'b0);
        idle(50);
        step(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
        check_eq("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_mid_busy", 32'(tx_busy), 32'd0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
            check_eq("rst_no_resume", 32'(uart_tx), 32'd1);
        end

        // Sustained writes against a full FIFO, several pointer laps
        $display("sustained writes at full");
        for (int i = 0; i < 1200; i++) begin
            v = 10'(i * 37 + 5);
            step(1'b1, v[9:4], v[3:0], 1'b0, 1'b0);
        end
        idle(5 * (REC_CYCLES + 1) + 10);
        check_eq("sustain_drained", 32'(exp_q.size()), 32'd0);
        check_eq("sustain_idle", 32'(tx_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
